// File: rtl/sass_input_conditioner_if.sv
// Raw breakout-board pins in, conditioned key/button levels and strobes out.
interface sass_input_conditioner_if #(
  parameter int unsigned NKEYS = 15
) ();
  logic [NKEYS-1:0] keys_raw;
  logic [2:0]       btn_raw;
  logic [NKEYS-1:0] keys_clean;
  logic             key_valid;
  logic [3:0]       key_code;
  logic             note_on;
  logic [2:0]       btn_clean;
  logic [2:0]       btn_press;

  // Board side: drives the pins and consumes the conditioned results.
  modport master (
    output keys_raw, btn_raw,
    input  keys_clean, key_valid, key_code, note_on, btn_clean, btn_press
  );

  // Conditioner side.
  modport slave (
    input  keys_raw, btn_raw,
    output keys_clean, key_valid, key_code, note_on, btn_clean, btn_press
  );
endinterface

// File: rtl/sass_input_conditioner.sv
// Synchronise, debounce and encode piano keys and sequencer buttons for sass_synth.
module sass_input_conditioner #(
  parameter int unsigned NKEYS    = 15,
  parameter int unsigned TICK_DIV = 10000,
  parameter int unsigned SAMPLES  = 4
) (
  input logic                clk,
  input logic                rst,
  sass_input_conditioner_if.slave bus
);

  localparam int unsigned NIN = NKEYS + 3;
  localparam int unsigned HW  = SAMPLES - 1;
  localparam int unsigned CW  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic [NIN-1:0] sync1;
  logic [NIN-1:0] sync2;
  logic [NIN-1:0] clean;
  logic [CW-1:0]  cnt;
  logic           tick;

  logic [NKEYS-1:0] keys_clean;
  logic [2:0]       btn_clean;
  logic             key_valid_q;
  logic [3:0]       key_code_q;
  logic             note_on_q;
  logic [2:0]       btn_prev;
  logic [2:0]       btn_press_q;
  logic             valid_nxt;
  logic [3:0]       code_nxt;

  assign keys_clean = clean[NKEYS-1:0];
  assign btn_clean  = clean[NIN-1:NKEYS];
  assign tick       = (cnt == CW'(TICK_DIV - 1));

  // Two-flop synchroniser on every raw pin, buttons packed above the keys.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= {bus.btn_raw, bus.keys_raw};
      sync2 <= sync1;
    end
  end

  // Free-running debounce sample-tick divider.
  always_ff @(posedge clk) begin
    if (rst) cnt <= '0;
    else if (tick) cnt <= '0;
    else cnt <= cnt + CW'(1);
  end

  // Per-input sample history; clean level flips only after SAMPLES agreeing ticks.
  for (genvar g = 0; g < NIN; g++) begin : g_deb
    logic [HW-1:0] hist;
    logic [HW-1:0] hist_shift;
    logic          lvl;

    if (HW > 1) begin : g_wide
      assign hist_shift = {hist[HW-2:0], sync2[g]};
    end else begin : g_narrow
      assign hist_shift = sync2[g];
    end

    // Shift in a new sample each tick and commit a change once history agrees.
    always_ff @(posedge clk) begin
      if (rst) begin
        hist <= '0;
        lvl  <= 1'b0;
      end else if (tick) begin
        hist <= hist_shift;
        if ((hist == {HW{sync2[g]}}) && (sync2[g] != lvl)) lvl <= sync2[g];
      end
    end

    assign clean[g] = lvl;
  end

  // Priority encoder: highest pressed key index wins.
  always_comb begin
    valid_nxt = |keys_clean;
    code_nxt  = 4'd0;
    for (int i = 0; i < int'(NKEYS); i++) begin
      if (keys_clean[i]) code_nxt = 4'(i);
    end
  end

  // Registered encoder outputs, note-on strobe and button rising-edge pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      key_valid_q <= 1'b0;
      key_code_q  <= 4'd0;
      note_on_q   <= 1'b0;
      btn_prev    <= 3'b000;
      btn_press_q <= 3'b000;
    end else begin
      key_valid_q <= valid_nxt;
      key_code_q  <= code_nxt;
      note_on_q   <= valid_nxt && (!key_valid_q || (code_nxt != key_code_q));
      btn_prev    <= btn_clean;
      btn_press_q <= btn_clean & ~btn_prev;
    end
  end

  assign bus.keys_clean = keys_clean;
  assign bus.btn_clean  = btn_clean;
  assign bus.key_valid  = key_valid_q;
  assign bus.key_code   = key_code_q;
  assign bus.note_on    = note_on_q;
  assign bus.btn_press  = btn_press_q;

endmodule

// File: tb/tb_sass_input_conditioner.sv
// Directed self-checking bench for sass_input_conditioner (TICK_DIV=4, SAMPLES=3).
module tb_sass_input_conditioner;

  logic clk;
  logic rst;
  int   tests;
  int   fails;

  int         note_cnt;
  logic [3:0] note_code;
  int         press_evt;
  int         press2_cnt;
  logic [2:0] press_log;

  int         base_note;
  int         base_evt;
  int         base_p2;
  logic [14:0] acc;

  sass_input_conditioner_if #(.NKEYS(15)) bus ();

  sass_input_conditioner #(
    .NKEYS   (15),
    .TICK_DIV(4),
    .SAMPLES (3)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Event counters for strobes, sampled on the active edge before outputs update.
  always @(posedge clk) begin
    if (bus.note_on) begin
      note_cnt  <= note_cnt + 1;
      note_code <= bus.key_code;
    end
    if (|bus.btn_press) begin
      press_evt <= press_evt + 1;
      press_log <= bus.btn_press;
    end
    if (bus.btn_press[2]) press2_cnt <= press2_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_range(input string tag, input int n, input int lo, input int hi);
    tests++;
    assert ((n >= lo) && (n <= hi)) else begin
      fails++;
      $error("FAIL %s: observed %0d cycles expected %0d..%0d", tag, n, lo, hi);
    end
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  // Count cycles until keys_clean (or btn_clean) reaches exp, bounded.
  task automatic wait_for(input bit use_btn, input logic [14:0] exp,
                          input int lo, input int hi, input string tag);
    int n;
    logic [14:0] cur;
    n = 0;
    do begin
      @(negedge clk);
      n++;
      cur = use_btn ? 15'(bus.btn_clean) : bus.keys_clean;
    end while ((cur !== exp) && (n < hi + 5));
    chk_range(tag, n, lo, hi);
  endtask

  initial begin
    tests = 0; fails = 0;
    note_cnt = 0; press_evt = 0; press2_cnt = 0;
    note_code = 4'd0; press_log = 3'b000;
    rst = 1'b1;
    bus.keys_raw = 15'h7FFF;
    bus.btn_raw  = 3'b111;

    // 1: reset with all pins high, then full-latency detection of every key.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst_keys", 32'(bus.keys_clean), 32'h0);
      chk("rst_outs", {bus.key_valid, bus.key_code, bus.note_on, bus.btn_clean, bus.btn_press},
          32'h0);
    end
    base_note = note_cnt;
    rst = 1'b0;
    wait_for(1'b0, 15'h7FFF, 12, 15, "all_keys_lat");
    chk("all_btn_clean", 32'(bus.btn_clean), 32'h7);
    step(2);
    chk("all_code", 32'(bus.key_code), 32'd14);
    chk("all_valid", 32'(bus.key_valid), 32'd1);
    chk("all_note_cnt", 32'(note_cnt - base_note), 32'd1);
    chk("all_press", 32'(press_log), 32'h7);
    bus.keys_raw = '0;
    bus.btn_raw  = '0;
    wait_for(1'b0, 15'h0000, 11, 15, "all_release");
    step(3);
    chk("all_rel_valid", {bus.key_valid, bus.key_code}, 32'h0);
    chk("all_rel_note", 32'(note_cnt - base_note), 32'd1);

    // 2: short pulse rejected, long hold accepted.
    base_note = note_cnt;
    acc = '0;
    bus.keys_raw[5] = 1'b1;
    step(8);
    bus.keys_raw[5] = 1'b0;
    for (int i = 0; i < 24; i++) begin
      @(negedge clk);
      acc |= bus.keys_clean;
    end
    chk("glitch_clean", 32'(acc), 32'h0);
    chk("glitch_note", 32'(note_cnt - base_note), 32'd0);
    bus.keys_raw[5] = 1'b1;
    wait_for(1'b0, 15'h0020, 11, 15, "k5_lat");
    step(2);
    chk("k5_code", 32'(bus.key_code), 32'd5);
    step(10);
    chk("k5_note_once", 32'(note_cnt - base_note), 32'd1);
    bus.keys_raw[5] = 1'b0;
    wait_for(1'b0, 15'h0000, 11, 15, "k5_rel");
    step(2);

    // 3: priority and retrigger on release of the top key.
    bus.keys_raw[3] = 1'b1;
    wait_for(1'b0, 15'h0008, 11, 15, "k3_lat");
    step(2);
    chk("k3_code", 32'(bus.key_code), 32'd3);
    base_note = note_cnt;
    bus.keys_raw[9] = 1'b1;
    wait_for(1'b0, 15'h0208, 11, 15, "k9_lat");
    step(2);
    chk("k9_code", 32'(bus.key_code), 32'd9);
    chk("k9_note", {28'(note_cnt - base_note), note_code}, {28'd1, 4'd9});
    base_note = note_cnt;
    bus.keys_raw[9] = 1'b0;
    wait_for(1'b0, 15'h0008, 11, 15, "k9_rel");
    step(2);
    chk("retrig_code", 32'(bus.key_code), 32'd3);
    chk("retrig_note", {28'(note_cnt - base_note), note_code}, {28'd1, 4'd3});
    base_note = note_cnt;
    bus.keys_raw[3] = 1'b0;
    wait_for(1'b0, 15'h0000, 11, 15, "k3_rel");
    step(3);
    chk("none_outs", {bus.key_valid, bus.key_code}, 32'h0);
    chk("none_note", 32'(note_cnt - base_note), 32'd0);

    // 4: three keys rising together give a single strobe for the top one.
    base_note = note_cnt;
    bus.keys_raw = 15'h0884;
    wait_for(1'b0, 15'h0884, 11, 15, "multi_lat");
    step(4);
    chk("multi_code", 32'(bus.key_code), 32'd11);
    chk("multi_note", {28'(note_cnt - base_note), note_code}, {28'd1, 4'd11});
    bus.keys_raw = '0;
    wait_for(1'b0, 15'h0000, 11, 15, "multi_rel");
    step(2);

    // 5: buttons -- held press pulses once; two buttons pulse in the same cycle.
    base_p2  = press2_cnt;
    bus.btn_raw[2] = 1'b1;
    step(40);
    chk("play_clean", 32'(bus.btn_clean), 32'h4);
    chk("play_press", 32'(press2_cnt - base_p2), 32'd1);
    bus.btn_raw[2] = 1'b0;
    wait_for(1'b1, 15'h0000, 11, 15, "play_rel");
    step(3);
    chk("play_no_fall", 32'(press2_cnt - base_p2), 32'd1);
    base_evt = press_evt;
    bus.btn_raw = 3'b011;
    wait_for(1'b1, 15'h0003, 11, 15, "pair_lat");
    step(3);
    chk("pair_press", {28'(press_evt - base_evt), 1'b0, press_log}, {28'd1, 4'h3});
    bus.btn_raw = '0;
    wait_for(1'b1, 15'h0000, 11, 15, "pair_rel");
    step(2);

    // 6: reset mid-operation with a key held and already debounced.
    bus.keys_raw[4] = 1'b1;
    wait_for(1'b0, 15'h0010, 11, 15, "k4_lat");
    step(2);
    chk("k4_code", 32'(bus.key_code), 32'd4);
    rst = 1'b1;
    step(1);
    chk("midrst_outs", {bus.keys_clean, bus.key_valid, bus.key_code, bus.note_on}, 32'h0);
    step(1);
    base_note = note_cnt;
    rst = 1'b0;
    wait_for(1'b0, 15'h0010, 12, 15, "k4_redetect");
    step(2);
    chk("k4_renote", {28'(note_cnt - base_note), note_code}, {28'd1, 4'd4});

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
